block_fifo_n: RTL and testbench

Single-clock, N-buffer block FIFO; parametrised successor to the dual-clock ping-pong FIFO. A writer fills one of NUM_BUFFERS independent buffers and commits it as a block. A reader consumes committed blocks strictly in commit order, with first-word-fall-through data. It sits between same-clock producers and consumers (DMA engines, packet framers) that need more than two blocks in flight and guaranteed ordering.

---
 rtl/block_fifo_n.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_block_fifo_n.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_fifo_n.sv
// block_fifo_n: single-clock block FIFO with NUM_BUFFERS independent buffers.
//
// A writer claims an EMPTY buffer by raising its write_activate bit, fills it
// with write_strobe/write_data, and commits it by dropping the bit. Committed
// buffers enter an index queue and are offered to the reader strictly in
// commit order with first-word-fall-through read_data.
//
// Ports:
//   clk, rst_n        sole clock (rising edge), asynchronous active-low reset
//   write_ready       per-buffer EMPTY flags (claimable)
//   write_activate    writer claim, one-hot or zero; falling bit commits
//   write_fifo_size   constant buffer depth in words
//   write_strobe      write write_data into the claimed buffer
//   write_data        write word
//   starved           no buffer is FULL or READING
//   read_ready        a committed block is offered
//   read_activate     reader owns the offered block while high
//   read_count        word count of the offered/owned block
//   read_strobe       consume the current read_data word
//   read_data         current word (FWFT)
//   overflow          (only with BLOCK_FIFO_N_OVERFLOW_EN) sticky dropped-strobe flag
//
// Optional feature macro: BLOCK_FIFO_N_OVERFLOW_EN adds the overflow output.
module block_fifo_n #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned NUM_BUFFERS   = 2,
    parameter int unsigned COUNT_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [NUM_BUFFERS-1:0] write_ready,
    input  logic [NUM_BUFFERS-1:0] write_activate,
    output logic [COUNT_WIDTH-1:0] write_fifo_size,
    input  logic                   write_strobe,
    input  logic [DATA_WIDTH-1:0]  write_data,
    output logic                   starved,
    output logic                   read_ready,
    input  logic                   read_activate,
    output logic [COUNT_WIDTH-1:0] read_count,
    input  logic                   read_strobe,
    output logic [DATA_WIDTH-1:0]  read_data
`ifdef BLOCK_FIFO_N_OVERFLOW_EN
    ,
    output logic                   overflow
`endif
);

    localparam int unsigned DEPTH     = 1 << ADDRESS_WIDTH;
    localparam int unsigned BUF_W     = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1;
    localparam int unsigned CNT_W     = ADDRESS_WIDTH + 1;
    localparam int unsigned MEM_AW    = BUF_W + ADDRESS_WIDTH;
    localparam int unsigned MEM_WORDS = NUM_BUFFERS * DEPTH;

    typedef enum logic [1:0] {BufEmpty, BufFilling, BufFull, BufReading} buf_state_e;
    typedef enum logic [1:0] {RdIdle, RdOffer, RdOwn} rd_state_e;

    // Writer side
    buf_state_e             buf_state_q [NUM_BUFFERS];
    buf_state_e             buf_state_d [NUM_BUFFERS];
    logic [CNT_W-1:0]       wr_cnt_q    [NUM_BUFFERS];
    logic [CNT_W-1:0]       wr_cnt_d    [NUM_BUFFERS];
    logic [NUM_BUFFERS-1:0] wa_q, wa_d, wa_rise, wa_fall;
    logic                   wa_onehot, q_push, wr_hit, wr_accept;
    logic [BUF_W-1:0]       q_push_idx, wr_idx;
    logic [MEM_AW-1:0]      mem_waddr;

    // Commit queue
    logic [BUF_W-1:0]       q_idx_q [NUM_BUFFERS];
    logic [BUF_W-1:0]       q_idx_d [NUM_BUFFERS];
    logic [BUF_W-1:0]       q_head_q, q_head_d, q_tail_q, q_tail_d, head_idx;
    logic [BUF_W:0]         q_cnt_q, q_cnt_d;
    logic                   q_pop;

    // Reader side
    rd_state_e              rd_state_q, rd_state_d;
    logic                   rd_take, rd_release, rd_accept, rd_en;
    logic [BUF_W-1:0]       rd_buf_q, rd_buf_d;
    logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d, rd_cnt_q, rd_cnt_d;
    logic [MEM_AW-1:0]      rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

    logic [DATA_WIDTH-1:0]  mem [MEM_WORDS];

    function automatic logic [BUF_W-1:0] ptr_inc(input logic [BUF_W-1:0] p);
        return (p == BUF_W'(NUM_BUFFERS - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Buffer states, claim/commit detection and write datapath
    // ---------------------------------------------------------------------
    always_comb begin
        wa_d       = write_activate;
        wa_rise    = write_activate & ~wa_q;
        wa_fall    = wa_q & ~write_activate;
        wa_onehot  = $onehot(write_activate);
        buf_state_d = buf_state_q;
        wr_cnt_d    = wr_cnt_q;
        q_push      = 1'b0;
        q_push_idx  = '0;
        wr_hit      = 1'b0;
        wr_idx      = '0;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            case (buf_state_q[i])
                BufEmpty: begin
                    if (wa_rise[i] && wa_onehot) begin
                        buf_state_d[i] = BufFilling;
                        wr_cnt_d[i]    = '0;
                    end
                end
                BufFilling: begin
                    if (wa_fall[i]) begin
                        // Empty blocks are returned without being queued.
                        if (wr_cnt_q[i] != '0) begin
                            buf_state_d[i] = BufFull;
                            q_push         = 1'b1;
                            q_push_idx     = BUF_W'(i);
                        end else begin
                            buf_state_d[i] = BufEmpty;
                        end
                    end else if (write_activate[i] && !wr_hit) begin
                        wr_hit = 1'b1;
                        wr_idx = BUF_W'(i);
                    end
                end
                BufFull: begin
                    if (rd_take && (rd_buf_q == BUF_W'(i))) buf_state_d[i] = BufReading;
                end
                BufReading: begin
                    if (rd_release && (rd_buf_q == BUF_W'(i))) buf_state_d[i] = BufEmpty;
                end
                default: buf_state_d[i] = BufEmpty;
            endcase
        end
        // A full buffer drops further strobes and keeps its count.
        wr_accept = write_strobe && wr_hit && (wr_cnt_q[wr_idx] != CNT_W'(DEPTH));
        mem_waddr = {wr_idx, wr_cnt_q[wr_idx][ADDRESS_WIDTH-1:0]};
        if (wr_accept) wr_cnt_d[wr_idx] = wr_cnt_q[wr_idx] + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_accept) mem[mem_waddr] <= write_data;
    end

    // ---------------------------------------------------------------------
    // Commit-order index queue
    // ---------------------------------------------------------------------
    always_comb begin
        q_pop    = (rd_state_q == RdIdle) && (q_cnt_q != '0);
        head_idx = q_idx_q[q_head_q];
        q_idx_d  = q_idx_q;
        if (q_push) q_idx_d[q_tail_q] = q_push_idx;
        q_head_d = q_pop  ? ptr_inc(q_head_q) : q_head_q;
        q_tail_d = q_push ? ptr_inc(q_tail_q) : q_tail_q;
        case ({q_push, q_pop})
            2'b10:   q_cnt_d = q_cnt_q + 1'b1;
            2'b01:   q_cnt_d = q_cnt_q - 1'b1;
            default: q_cnt_d = q_cnt_q;
        endcase
    end

    // ---------------------------------------------------------------------
    // Reader FSM: state register / next state / outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_state_q <= RdIdle;
        else        rd_state_q <= rd_state_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            RdIdle:  if (q_pop) rd_state_d = RdOffer;
            RdOffer: if (read_activate) rd_state_d = RdOwn;
            RdOwn:   if (!read_activate) rd_state_d = RdIdle;
            default: rd_state_d = RdIdle;
        endcase
    end

    always_comb begin
        read_ready = (rd_state_q == RdOffer);
        rd_take    = (rd_state_q == RdOffer) && read_activate;
        rd_release = (rd_state_q == RdOwn) && !read_activate;
        rd_accept  = (rd_state_q == RdOwn) && read_activate && read_strobe &&
                     (rd_ptr_q != rd_cnt_q);
    end

    // Read datapath: rd_ptr counts consumed words; the RAM is only read while
    // another unconsumed word exists, so read_data holds the last word.
    always_comb begin
        rd_buf_d = rd_buf_q;
        rd_ptr_d = rd_ptr_q;
        rd_cnt_d = rd_cnt_q;
        rd_en    = 1'b0;
        rd_addr  = '0;
        if (q_pop) begin
            rd_buf_d = head_idx;
            rd_ptr_d = '0;
            rd_cnt_d = wr_cnt_q[head_idx];
            rd_en    = 1'b1;
            rd_addr  = {head_idx, ADDRESS_WIDTH'(0)};
        end else if (rd_release) begin
            rd_ptr_d = '0;
            rd_cnt_d = '0;
        end else if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (rd_ptr_d != rd_cnt_q) begin
                rd_en   = 1'b1;
                rd_addr = {rd_buf_q, rd_ptr_d[ADDRESS_WIDTH-1:0]};
            end
        end
        rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                buf_state_q[i] <= BufEmpty;
                wr_cnt_q[i]    <= '0;
                q_idx_q[i]     <= '0;
            end
            wa_q      <= '0;
            q_head_q  <= '0;
            q_tail_q  <= '0;
            q_cnt_q   <= '0;
            rd_buf_q  <= '0;
            rd_ptr_q  <= '0;
            rd_cnt_q  <= '0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_BUFFERS; i++) begin
                buf_state_q[i] <= buf_state_d[i];
                wr_cnt_q[i]    <= wr_cnt_d[i];
                q_idx_q[i]     <= q_idx_d[i];
            end
            wa_q      <= wa_d;
            q_head_q  <= q_head_d;
            q_tail_q  <= q_tail_d;
            q_cnt_q   <= q_cnt_d;
            rd_buf_q  <= rd_buf_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_cnt_q  <= rd_cnt_d;
            rd_data_q <= rd_data_d;
        end
    end

    // ---------------------------------------------------------------------
    // Status outputs
    // ---------------------------------------------------------------------
    always_comb begin
        write_ready = '0;
        starved     = 1'b1;
        for (int i = 0; i < NUM_BUFFERS; i++) begin
            write_ready[i] = (buf_state_q[i] == BufEmpty);
            if ((buf_state_q[i] == BufFull) || (buf_state_q[i] == BufReading)) starved = 1'b0;
        end
    end

    assign write_fifo_size = COUNT_WIDTH'(DEPTH);
    assign read_count      = COUNT_WIDTH'(rd_cnt_q);
    assign read_data       = rd_data_q;

`ifdef BLOCK_FIFO_N_OVERFLOW_EN
    logic overflow_q, overflow_d, claim_valid;

    always_comb begin
        claim_valid = wa_onehot && (|(wa_rise & write_ready));
        overflow_d  = overflow_q;
        if (claim_valid) overflow_d = 1'b0;
        // A drop in the claim cycle itself still leaves the flag set.
        if ((write_strobe && !wr_accept) || (read_strobe && !rd_accept)) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_block_fifo_n.sv
// Self-checking bench for block_fifo_n (NUM_BUFFERS=4, DEPTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_block_fifo_n;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int NB    = 4;
    localparam int CW    = 24;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] write_ready;
    logic [NB-1:0] write_activate = '0;
    logic [CW-1:0] write_fifo_size;
    logic          write_strobe = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          starved;
    logic          read_ready;
    logic          read_activate = 1'b0;
    logic [CW-1:0] read_count;
    logic          read_strobe = 1'b0;
    logic [DW-1:0] read_data;
`ifdef BLOCK_FIFO_N_OVERFLOW_EN
    logic          overflow;
`endif

    block_fifo_n #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .NUM_BUFFERS  (NB),
        .COUNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_ready    (write_ready),
        .write_activate (write_activate),
        .write_fifo_size(write_fifo_size),
        .write_strobe   (write_strobe),
        .write_data     (write_data),
        .starved        (starved),
        .read_ready     (read_ready),
        .read_activate  (read_activate),
        .read_count     (read_count),
        .read_strobe    (read_strobe),
        .read_data      (read_data)
`ifdef BLOCK_FIFO_N_OVERFLOW_EN
        ,
        .overflow       (overflow)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: contents of each buffer as written, and commit order.
    logic [DW-1:0] blk_mem [NB][DEPTH];
    int            blk_len [NB];
    int            exp_q[$];
    // Observations captured while consuming a block.
    logic [DW-1:0] obs_q[$];
    int            obs_cnt;
    logic [DW-1:0] obs_last;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < NB; i++) blk_len[i] = 0;
    endtask

    task automatic claim_buf(input int b);
        write_activate = NB'(1 << b);
        blk_len[b] = 0;
        step();
    endtask

    task automatic write_words(input int b, input int n, input bit fixed, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            write_strobe = 1'b1;
            write_data   = fixed ? base + DW'(k) : DW'($urandom);
            if (blk_len[b] < DEPTH) begin
                blk_mem[b][blk_len[b]] = write_data;
                blk_len[b]++;
            end
            step();
        end
        write_strobe = 1'b0;
    endtask

    task automatic commit_buf(input int b);
        write_activate = '0;
        if (blk_len[b] > 0) exp_q.push_back(b);
        step();
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = (read_ready === 1'b1);
        for (int k = 0; k < budget && !ok; k++) begin
            step();
            ok = (read_ready === 1'b1);
        end
    endtask

    // Take the offered block, issue nstr strobes recording read_data before
    // each, then optionally release.
    task automatic consume(input int nstr, input bit do_release);
        obs_q.delete();
        obs_cnt = int'(read_count);
        read_activate = 1'b1;
        step();
        for (int k = 0; k < nstr; k++) begin
            obs_q.push_back(read_data);
            read_strobe = 1'b1;
            step();
        end
        read_strobe = 1'b0;
        obs_last = read_data;
        if (do_release) begin
            read_activate = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        write_activate = '0; write_strobe = 1'b0; read_activate = 1'b0; read_strobe = 1'b0;
        model_clear();
        repeat (3) step();
        tests_run++;
        if (write_ready !== 4'b1111) begin tests_failed++;
            $display("FAIL reset_write_ready: got %b want 1111", write_ready); end
        tests_run++;
        if (starved !== 1'b1) begin tests_failed++;
            $display("FAIL reset_starved: got %b want 1", starved); end
        tests_run++;
        if (read_ready !== 1'b0) begin tests_failed++;
            $display("FAIL reset_read_ready: got %b want 0", read_ready); end
        tests_run++;
        if (read_count !== 24'd0) begin tests_failed++;
            $display("FAIL reset_read_count: got %0d want 0", read_count); end
        tests_run++;
        if (read_data !== 32'd0) begin tests_failed++;
            $display("FAIL reset_read_data: got %h want 0", read_data); end
        tests_run++;
        if (write_fifo_size !== 24'(DEPTH)) begin tests_failed++;
            $display("FAIL fifo_size: got %0d want %0d", write_fifo_size, DEPTH); end
`ifdef BLOCK_FIFO_N_OVERFLOW_EN
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++;
            $display("FAIL reset_overflow: got %b want 0", overflow); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        claim_buf(0);
        tests_run++;
        if (write_ready !== 4'b1110) begin tests_failed++;
            $display("FAIL claim_write_ready: got %b want 1110", write_ready); end
        write_words(0, 5, 1'b1, 32'h10);
        commit_buf(0);
        tests_run++;
        if (read_ready !== 1'b0) begin tests_failed++;
            $display("FAIL commit_plus1_ready: got %b want 0", read_ready); end
        tests_run++;
        if (starved !== 1'b0) begin tests_failed++;
            $display("FAIL commit_starved: got %b want 0", starved); end
        step();
        tests_run++;
        if (read_ready !== 1'b1) begin tests_failed++;
            $display("FAIL commit_plus2_ready: got %b want 1", read_ready); end
        tests_run++;
        if (read_count !== 24'd5) begin tests_failed++;
            $display("FAIL basic_read_count: got %0d want 5", read_count); end
        tests_run++;
        if (read_data !== 32'h10) begin tests_failed++;
            $display("FAIL basic_fwft_word0: got %h want 10", read_data); end
        void'(exp_q.pop_front());
        consume(6, 1'b1);
        for (int k = 0; k < 6; k++) begin
            logic [DW-1:0] want;
            want = (k < 5) ? 32'h10 + DW'(k) : 32'h14;
            tests_run++;
            if (obs_q[k] !== want) begin tests_failed++;
                $display("FAIL basic_word%0d: got %h want %h", k, obs_q[k], want); end
        end
        tests_run++;
        if (obs_last !== 32'h14) begin tests_failed++;
            $display("FAIL basic_hold_last: got %h want 14", obs_last); end
        blk_len[0] = 0;
        tests_run++;
        if (write_ready !== 4'b1111) begin tests_failed++;
            $display("FAIL basic_release_ready: got %b want 1111", write_ready); end
        tests_run++;
        if (read_count !== 24'd0) begin tests_failed++;
            $display("FAIL basic_release_count: got %0d want 0", read_count); end
        tests_run++;
        if (starved !== 1'b1) begin tests_failed++;
            $display("FAIL basic_release_starved: got %b want 1", starved); end
    endtask

    // Drain every queued block with full reads and compare to the model.
    task automatic drain_all(input string tag, input bit rand_len);
        while (exp_q.size() > 0) begin
            bit ok;
            int b;
            int len;
            int nstr;
            int idx;
            wait_ready(12, ok);
            tests_run++;
            if (ok !== 1'b1) begin tests_failed++;
                $display("FAIL %s_offer_timeout: read_ready=%b want 1", tag, read_ready);
                break;
            end
            b    = exp_q.pop_front();
            len  = blk_len[b];
            nstr = rand_len ? int'($urandom_range(len + 2, 0)) : len;
            consume(nstr, 1'b1);
            tests_run++;
            if (obs_cnt !== len) begin tests_failed++;
                $display("FAIL %s_count_buf%0d: got %0d want %0d", tag, b, obs_cnt, len); end
            for (int k = 0; k < nstr; k++) begin
                idx = (k < len) ? k : len - 1;
                tests_run++;
                if (obs_q[k] !== blk_mem[b][idx]) begin tests_failed++;
                    $display("FAIL %s_buf%0d_word%0d: got %h want %h", tag, b, k, obs_q[k],
                             blk_mem[b][idx]); end
            end
            idx = (nstr < len) ? nstr : len - 1;
            tests_run++;
            if (obs_last !== blk_mem[b][idx]) begin tests_failed++;
                $display("FAIL %s_buf%0d_last: got %h want %h", tag, b, obs_last, blk_mem[b][idx]); end
            blk_len[b] = 0;
        end
    endtask

    task automatic test_ordering();
        claim_buf(2); write_words(2, 3, 1'b0, '0); commit_buf(2);
        claim_buf(0); write_words(0, 7, 1'b0, '0); commit_buf(0);
        drain_all("order", 1'b0);
    endtask

    task automatic test_overflow();
        claim_buf(1);
        write_words(1, 20, 1'b0, '0);
`ifdef BLOCK_FIFO_N_OVERFLOW_EN
        tests_run++;
        if (overflow !== 1'b1) begin tests_failed++;
            $display("FAIL overflow_set: got %b want 1", overflow); end
`endif
        commit_buf(1);
        drain_all("ovf", 1'b0);
`ifdef BLOCK_FIFO_N_OVERFLOW_EN
        claim_buf(1);
        tests_run++;
        if (overflow !== 1'b0) begin tests_failed++;
            $display("FAIL overflow_clear: got %b want 0", overflow); end
        commit_buf(1);
`endif
    endtask

    task automatic test_early_release();
        bit ok;
        claim_buf(3); write_words(3, 8, 1'b0, '0); commit_buf(3);
        wait_ready(12, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++;
            $display("FAIL early_offer_timeout: read_ready=%b want 1", read_ready); end
        void'(exp_q.pop_front());
        consume(2, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (obs_q[k] !== blk_mem[3][k]) begin tests_failed++;
                $display("FAIL early_word%0d: got %h want %h", k, obs_q[k], blk_mem[3][k]); end
        end
        tests_run++;
        if (write_ready[3] !== 1'b1) begin tests_failed++;
            $display("FAIL early_release_ready: got %b want 1", write_ready[3]); end
        blk_len[3] = 0;
        claim_buf(3); write_words(3, 4, 1'b0, '0); commit_buf(3);
        drain_all("early_refill", 1'b0);
    endtask

    task automatic test_simultaneous();
        bit ok;
        int highs;
        claim_buf(0); write_words(0, 3, 1'b0, '0); commit_buf(0);
        wait_ready(12, ok);
        tests_run++;
        if (ok !== 1'b1) begin tests_failed++;
            $display("FAIL simul_offer_timeout: read_ready=%b want 1", read_ready); end
        read_activate = 1'b1;
        step();
        void'(exp_q.pop_front());
        claim_buf(1); write_words(1, 4, 1'b0, '0);
        // Commit buf1 and release buf0 in the same cycle.
        write_activate = '0;
        read_activate  = 1'b0;
        exp_q.push_back(1);
        blk_len[0] = 0;
        step();
        tests_run++;
        if (write_ready[0] !== 1'b1) begin tests_failed++;
            $display("FAIL simul_buf0_free: got %b want 1", write_ready[0]); end
        tests_run++;
        if (read_ready !== 1'b0) begin tests_failed++;
            $display("FAIL simul_plus1_ready: got %b want 0", read_ready); end
        claim_buf(0);
        tests_run++;
        if (read_ready !== 1'b1) begin tests_failed++;
            $display("FAIL simul_plus2_ready: got %b want 1", read_ready); end
        tests_run++;
        if (read_count !== 24'd4) begin tests_failed++;
            $display("FAIL simul_count: got %0d want 4", read_count); end
        tests_run++;
        if (write_ready[0] !== 1'b0) begin tests_failed++;
            $display("FAIL simul_buf0_claimed: got %b want 0", write_ready[0]); end
        commit_buf(0);
        tests_run++;
        if (write_ready[0] !== 1'b1) begin tests_failed++;
            $display("FAIL zero_commit_free: got %b want 1", write_ready[0]); end
        drain_all("simul", 1'b0);
        highs = 0;
        for (int k = 0; k < 6; k++) begin
            if (read_ready === 1'b1) highs++;
            step();
        end
        tests_run++;
        if (highs !== 0) begin tests_failed++;
            $display("FAIL zero_commit_offer: read_ready high %0d cycles want 0", highs); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        int highs;
        claim_buf(2); write_words(2, 6, 1'b0, '0); commit_buf(2);
        wait_ready(12, ok);
        read_activate = 1'b1;
        step();
        read_strobe = 1'b1; step(); step();
        read_strobe = 1'b0;
        claim_buf(1); write_words(1, 3, 1'b0, '0); commit_buf(1);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (write_ready !== 4'b1111) begin tests_failed++;
            $display("FAIL midrst_write_ready: got %b want 1111", write_ready); end
        tests_run++;
        if (read_ready !== 1'b0) begin tests_failed++;
            $display("FAIL midrst_read_ready: got %b want 0", read_ready); end
        tests_run++;
        if (read_count !== 24'd0) begin tests_failed++;
            $display("FAIL midrst_read_count: got %0d want 0", read_count); end
        tests_run++;
        if (read_data !== 32'd0) begin tests_failed++;
            $display("FAIL midrst_read_data: got %h want 0", read_data); end
        tests_run++;
        if (starved !== 1'b1) begin tests_failed++;
            $display("FAIL midrst_starved: got %b want 1", starved); end
        write_activate = '0; read_activate = 1'b0; read_strobe = 1'b0; write_strobe = 1'b0;
        model_clear();
        step();
        rst_n = 1'b1;
        highs = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (read_ready === 1'b1) highs++;
        end
        tests_run++;
        if (highs !== 0) begin tests_failed++;
            $display("FAIL midrst_stale_offer: read_ready high %0d cycles want 0", highs); end
    endtask

    task automatic test_random();
        int perm [NB];
        for (int it = 0; it < 8; it++) begin
            int nblk;
            for (int i = 0; i < NB; i++) perm[i] = i;
            for (int i = NB - 1; i > 0; i--) begin
                int j;
                int t;
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            nblk = int'($urandom_range(3, 1));
            for (int k = 0; k < nblk; k++) begin
                claim_buf(perm[k]);
                write_words(perm[k], int'($urandom_range(18, 0)), 1'b0, '0);
                commit_buf(perm[k]);
            end
            drain_all("rand", 1'b1);
            tests_run++;
            if (write_ready !== 4'b1111) begin tests_failed++;
                $display("FAIL rand_all_free_it%0d: got %b want 1111", it, write_ready); end
            tests_run++;
            if (starved !== 1'b1) begin tests_failed++;
                $display("FAIL rand_starved_it%0d: got %b want 1", it, starved); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_ordering();
        test_overflow();
        test_early_release();
        test_simultaneous();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
